// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A WIDTH+1-bit trial subtraction decides each bit; a negative trial
// result keeps the shifted partial remainder, which is the "restore" step.
//
// Handshake: start is accepted on a rising edge whenever the block is not
// in RUN (IDLE or DONE), so a new operation can follow DONE with no idle
// cycle. done is high for exactly the one cycle spent in DONE. There is no
// backpressure: the result registers hold their value until the next
// result is written, so a consumer may read them at any later time.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Partial remainder stays below the divisor, so WIDTH bits hold it; the
  // extra bit only exists in the shifted value fed to the subtractor.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             last_iter;

  // One shift/trial-subtract/restore step and the start acceptance decode.
  always_comb begin
    accept    = start && (state != RUN);
    last_iter = (count == CW'(WIDTH - 1));
    r_shift   = {r, q[WIDTH-1]};
    r_trial   = r_shift - {1'b0, d};
    r_next    = r_trial[WIDTH] ? r_shift[WIDTH-1:0] : r_trial[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], ~r_trial[WIDTH]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r     <= '0;
      q     <= dividend;
      d     <= divisor;
      count <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r     <= r_next;
      q     <= q_next;
      count <= count + CW'(1);
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: expected results come from the
// integer / and % operators and are queued when an operation is started.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  logic [2*W:0] exp_q[$];
  int vectors;
  int miscompares;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    logic [W-1:0] qq;
    logic [W-1:0] rr;
    if (dv == '0) begin
      return {1'b1, {W{1'b1}}, dd};
    end
    qq = dd / dv;
    rr = dd % dv;
    return {1'b0, qq, rr};
  endfunction

  // Wait n cycles with start low and count any done pulses seen.
  task automatic quiet(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  // Drive one operation from the current time, queue its expected result,
  // then wait for done. Returns in the DONE cycle, so a following call
  // exercises back-to-back acceptance. poke_at > 0 pulses a second start
  // during RUN at that cycle count.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input int exp_lat, input int poke_at, input string tag);
    logic [2*W:0] prev;
    logic [2*W:0] got;
    logic [2*W:0] exp;
    int n;
    int busy_cycles;
    bit held_ok;
    prev = {div_by_zero, quotient, remainder};
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    exp_q.push_back(model(dd, dv));
    n = 0;
    busy_cycles = 0;
    held_ok = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (done) break;
      if (busy) busy_cycles++;
      if ({div_by_zero, quotient, remainder} !== prev) held_ok = 1'b0;
      dividend = W'($urandom_range(0, 255));
      divisor = W'($urandom_range(0, 255));
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy cycles"}, busy_cycles, exp_lat - 1);
    check({tag, " held during run"}, held_ok, 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {div_by_zero, quotient, remainder};
      check({tag, " result"}, got, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(8'd200, 8'd7, 9, 0, "200/7");
    quiet(1, "200/7 single done");
    run_op(8'd255, 8'd1, 9, 0, "255/1");
    quiet(1, "gap");
    run_op(8'd5, 8'd9, 9, 0, "5/9");
    quiet(1, "gap");
    run_op(8'd0, 8'd3, 9, 0, "0/3");
    quiet(1, "gap");
    run_op(8'd255, 8'd255, 9, 0, "255/255");
    quiet(1, "gap");

    run_op(8'd100, 8'd0, 1, 0, "100/0");
    quiet(1, "100/0 single done");
    run_op(8'd10, 8'd3, 9, 0, "10/3 after div0");
    quiet(1, "gap");

    run_op(8'd50, 8'd5, 9, 3, "50/5 poked");
    quiet(12, "50/5 no second done");

    run_op(8'd77, 8'd8, 9, 0, "77/8");
    run_op(8'd60, 8'd7, 9, 0, "60/7 back-to-back");
    quiet(1, "60/7 single done");

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = (i == 4) ? '0 : W'($urandom_range(1, 255));
      run_op(a, b, (b == '0) ? 1 : 9, 0, "random");
      quiet(1, "random gap");
    end

    // Abort 123/4 with an asynchronous reset in the middle of RUN.
    start = 1'b1;
    dividend = 8'd123;
    divisor = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy before reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    quiet(3, "abort no done in reset");
    rst_n = 1'b1;
    quiet(10, "abort no done after release");
    run_op(8'd123, 8'd4, 9, 0, "123/4 after abort");
    quiet(1, "gap");

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
